// File: rtl/stream_data_loader.sv
// stream_data_loader
//
// Multi-channel sample store and streamer. Samples are loaded per channel
// through a simple write port, then streamed (all channels in lockstep) over
// a valid/ready handshake while a per-channel sum is accumulated. Repeat mode
// replays the buffer continuously until aborted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/wr_ch/wr_addr/wr_data   sample write port (IDLE or DONE only)
//   start, len, repeat_mode       launch a run of len samples
//   abort             drop the current run, back to IDLE
//   out_ready         consumer ready
//   out_valid/out_data/out_idx/out_last   presented sample (channel c in
//                     out_data[c*WIDTH +: WIDTH])
//   sum, sum_valid    per-channel totals of the last completed pass + pulse
//   done              one-cycle pulse at the end of a non-repeat run
//   busy              streaming in progress
//   err               sticky error, cleared by the next accepted start
module stream_data_loader #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 10,
  parameter int DEPTH = 150,
  parameter int CH    = 2,
  parameter int AW    = 8,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int SW   = WIDTH + AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_ch,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                start,
  input  logic [AW-1:0]       len,
  input  logic                repeat_mode,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [AW-1:0]       out_idx,
  output logic                out_last,
  output logic [CH*SW-1:0]    sum,
  output logic                sum_valid,
  output logic                done,
  output logic                busy,
  output logic                err
);

  // Elaboration-time parameter sanity checks.
  if ((1 << AW) <= DEPTH) begin : g_aw_check
    $error("AW too small to index DEPTH samples");
  end
  if (FRAC > WIDTH) begin : g_frac_check
    $error("FRAC exceeds WIDTH");
  end

  localparam logic [AW-1:0]  DEPTH_A = AW'(DEPTH);
  localparam logic [CHW:0]   CH_W    = (CHW + 1)'(CH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Sample storage; intentionally not reset.
  logic [WIDTH-1:0] mem_q [CH][DEPTH];

  state_t                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           len_q, len_d;
  logic                    rpt_q, rpt_d;
  logic [CH-1:0][SW-1:0]   acc_q, acc_d;
  logic [CH-1:0][SW-1:0]   sum_q, sum_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    err_q, err_d;

  logic [CH-1:0][WIDTH-1:0] rd_data;
  logic [CH-1:0][SW-1:0]    acc_inc;
  logic                     wr_in_range;
  logic                     wr_ok;
  logic                     len_ok;
  logic                     is_last;

  // Combinational read: the presented sample follows idx with no bubble, and
  // a write landing on the start edge is already visible on the first beat.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign rd_data[gi]                    = mem_q[gi][idx_q];
    assign out_data[gi*WIDTH +: WIDTH]    = rd_data[gi];
    assign acc_inc[gi]                    = acc_q[gi] + {{AW{1'b0}}, rd_data[gi]};
  end

  assign wr_in_range = ({1'b0, wr_ch} < CH_W) && (wr_addr < DEPTH_A);
  assign wr_ok       = wr_en && wr_in_range && (state_q != S_STREAM);
  assign len_ok      = (len != '0) && (len <= DEPTH_A);
  assign is_last     = (idx_q == (len_q - AW'(1)));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ch][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    rpt_d       = rpt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = S_STREAM;
            len_d   = len;
            rpt_d   = repeat_mode;
            idx_d   = '0;
            acc_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        // Abort wins over a same-cycle handshake; that beat is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (is_last) begin
            sum_d       = acc_inc;
            sum_valid_d = 1'b1;
            if (rpt_q) begin
              idx_d = '0;
              acc_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + AW'(1);
            acc_d = acc_inc;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A rejected write flags an error even on the cycle a start clears it.
    if (wr_en && ((state_q == S_STREAM) || !wr_in_range)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      rpt_q       <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      rpt_q       <= rpt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = (state_q == S_STREAM);
  assign busy      = (state_q == S_STREAM);
  assign done      = (state_q == S_DONE);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == S_STREAM) && is_last;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stream_data_loader.sv
// Testbench for stream_data_loader: directed stimulus, expected beats and
// sums pushed into queues, a negedge monitor pops and compares them.
module tb_stream_data_loader;

  localparam int W  = 20;
  localparam int AW = 8;
  localparam int CH = 2;
  localparam int SW = W + AW;
  localparam int DEPTH = 150;

  typedef struct packed {
    logic [AW-1:0]   idx;
    logic [CH*W-1:0] data;
    logic            last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [0:0]        wr_ch = '0;
  logic [AW-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              start = 1'b0;
  logic [AW-1:0]     len = '0;
  logic              repeat_mode = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [CH*W-1:0]   out_data;
  logic [AW-1:0]     out_idx;
  logic              out_last;
  logic [CH*SW-1:0]  sum;
  logic              sum_valid;
  logic              done;
  logic              busy;
  logic              err;

  stream_data_loader dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .repeat_mode(repeat_mode), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .sum(sum), .sum_valid(sum_valid),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_beats = 0;
  int n_sumv  = 0;
  int n_done  = 0;

  beat_t            exp_beats[$];
  logic [CH*SW-1:0] exp_sums[$];
  logic [W-1:0]     mem_m [CH][DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat and every sum pulse is checked against the
  // queues filled by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready && !abort) begin
        n_beats++;
        if (exp_beats.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat_unexpected: got idx %0d expected no beat", out_idx);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          chk("beat_idx", 64'(out_idx), 64'(b.idx));
          chk("beat_data", 64'(out_data), 64'(b.data));
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
      end
      if (sum_valid) begin
        n_sumv++;
        if (exp_sums.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sum_unexpected: got %0h expected no sum", sum);
        end else begin
          logic [CH*SW-1:0] s;
          s = exp_sums.pop_front();
          chk("sum", 64'(sum), 64'(s));
          $display("sum pass: %0h", sum);
        end
      end
      if (done) n_done++;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic wr(input int ch, input int addr, input logic [W-1:0] d, input bit ok);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = AW'(addr); wr_data = d;
    if (ok) mem_m[ch][addr] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int l, input bit r);
    start = 1'b1; len = AW'(l); repeat_mode = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_run(input int l);
    beat_t b;
    for (int i = 0; i < l; i++) begin
      b.idx  = AW'(i);
      b.data = {mem_m[1][i], mem_m[0][i]};
      b.last = (i == l - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic wait_done(input string tag, input bit toggle);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (toggle) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", tag);
    end else begin
      chk({tag, "_sumv_with_done"}, 64'(sum_valid), 64'd1);
      chk({tag, "_valid_low_at_done"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_idle_after_done"}, 64'(busy), 64'd0);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    $display("run %s finished: beats=%0d sums=%0d", tag, n_beats, n_sumv);
  endtask

  initial begin
    int b0, s0, d0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load: ch0 = 1.0, 2.0, 3.0, 0.5 ; ch1 = 4 x 1.0
    wr(0, 0, 20'h00400, 1'b1);
    wr(0, 1, 20'h00800, 1'b1);
    wr(0, 2, 20'h00C00, 1'b1);
    wr(0, 3, 20'h00200, 1'b1);
    for (int i = 0; i < 4; i++) wr(1, i, 20'h00400, 1'b1);

    // Basic run, ready held high
    out_ready = 1'b1;
    push_run(4);
    exp_sums.push_back({28'h0001000, 28'h0001A00});
    b0 = n_beats;
    start_run(4, 1'b0);
    @(negedge clk);
    chk("first_beat_valid", 64'(out_valid), 64'd1);
    chk("first_beat_idx", 64'(out_idx), 64'd0);
    @(posedge clk); #1;
    wait_done("basic", 1'b0);
    chk("basic_beats", 64'(n_beats - b0), 64'd4);

    // Same data with ready toggling 1,0,0,1
    push_run(4);
    exp_sums.push_back({28'h0001000, 28'h0001A00});
    b0 = n_beats;
    out_ready = 1'b0;
    start_run(4, 1'b0);
    wait_done("stall", 1'b1);
    chk("stall_beats", 64'(n_beats - b0), 64'd4);

    // Repeat mode, len 2, three passes then abort
    for (int p = 0; p < 3; p++) begin
      push_run(2);
      exp_sums.push_back({28'h0000800, 28'h0000C00});
    end
    b0 = n_beats; s0 = n_sumv; d0 = n_done;
    out_ready = 1'b1;
    start_run(2, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("repeat_beats", 64'(n_beats - b0), 64'd6);
    chk("repeat_sums", 64'(n_sumv - s0), 64'd3);
    chk("repeat_no_done", 64'(n_done - d0), 64'd0);
    @(posedge clk); #1;

    // Error handling
    start_run(0, 1'b0);
    @(negedge clk);
    chk("len0_err", 64'(err), 64'd1);
    chk("len0_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_run(1, 1'b0);
    @(negedge clk);
    chk("start_clears_err", 64'(err), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    wr(0, 0, 20'h12345, 1'b0);
    @(negedge clk);
    chk("wr_in_stream_err", 64'(err), 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    push_run(1);
    exp_sums.push_back({28'h0000400, 28'h0000400});
    out_ready = 1'b1;
    start_run(1, 1'b0);
    wait_done("len1", 1'b0);
    start_run(151, 1'b0);
    @(negedge clk);
    chk("len151_err", 64'(err), 64'd1);
    chk("len151_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Reset mid-stream while idx 2 is presented
    exp_beats.push_back('{idx: 8'd0, data: {mem_m[1][0], mem_m[0][0]}, last: 1'b0});
    exp_beats.push_back('{idx: 8'd1, data: {mem_m[1][1], mem_m[0][1]}, last: 1'b0});
    start_run(4, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_idx", 64'(out_idx), 64'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_idx", 64'(out_idx), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    push_run(4);
    exp_sums.push_back({28'h0001000, 28'h0001A00});
    start_run(4, 1'b0);
    wait_done("restart", 1'b0);

    // Full depth, all ones; last ch1 entry written on the start edge
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++)
        wr(c, i, (c == 1 && i == DEPTH - 1) ? 20'h00000 : 20'hFFFFF, 1'b1);
    mem_m[1][DEPTH-1] = 20'hFFFFF;
    push_run(DEPTH);
    exp_sums.push_back({28'd157286250, 28'd157286250});
    b0 = n_beats;
    wr_en = 1'b1; wr_ch = 1'b1; wr_addr = AW'(DEPTH - 1); wr_data = 20'hFFFFF;
    start_run(DEPTH, 1'b0);
    wr_en = 1'b0;
    wait_done("full", 1'b0);
    chk("full_beats", 64'(n_beats - b0), 64'(DEPTH));

    // Out-of-range write address
    wr(0, DEPTH, 20'h00001, 1'b0);
    @(negedge clk);
    chk("wr_oob_err", 64'(err), 64'd1);
    @(posedge clk); #1;

    chk("beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("sums_drained", 64'(exp_sums.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_data_loader.md
# stream_data_loader

Parametrised multi-channel sample store and streamer for the regression datapath. Software/testbench writes up to DEPTH fixed-point samples per channel through a write port. On `start` the block streams a programmable number of samples, all channels in lockstep, over a valid/ready handshake, and accumulates a per-channel sum. A repeat mode replays the buffer continuously for multi-epoch training without reloading.

## Interface
- `WIDTH`, 20: sample width; unsigned fixed point, `WIDTH-FRAC` integer bits.
- `FRAC`, 10: fractional bits. Informational only; the arithmetic is unaffected.
- `DEPTH`, 150: samples per channel.
- `CH`, 2: channel count (channel 0 = x, channel 1 = y).
- `AW`, 8: address/index width; must satisfy 2^AW > DEPTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write strobe.
- `wr_ch`  in  clog2(CH) (min 1)  write channel.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  WIDTH  write data.
- `start`  in  1  begin streaming.
- `len`  in  AW  sample count, sampled on `start`.
- `repeat_mode`  in  1  loop continuously, sampled on `start`.
- `abort`  in  1  stop streaming.
- `out_ready`  in  1  consumer ready.
- `out_valid`  out  1  sample available.
- `out_data`  out  CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
- `out_idx`  out  AW  index of the presented sample.
- `out_last`  out  1  presented sample is index len-1.
- `sum`  out  CH*(WIDTH+AW)  per-channel totals of the last completed pass.
- `sum_valid`  out  1  one-cycle pulse when `sum` updates.
- `done`  out  1  one-cycle pulse at the end of a non-repeat run.
- `busy`  out  1  state is STREAM.
- `err`  out  1  sticky error flag; cleared on the next accepted start.

## Operation
- Storage: CH×DEPTH×WIDTH register array. It is not reset; contents are undefined until written.
- Writes:
  - Accepted when `wr_en=1` in IDLE or DONE.
  - Ignored in STREAM, and `err` is set.
  - `wr_addr>=DEPTH` or `wr_ch>=CH`: write ignored, `err` set.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - `start` with 1≤`len`≤DEPTH: latch `len` and `repeat_mode`, idx←0, clear accumulators, clear `err`, go to STREAM.
  - `start` with `len`=0 or `len`>DEPTH: stay in IDLE, set `err`.
- STREAM:
  - `out_valid`=1.
  - `out_data` = mem[c][idx] for every channel.
  - `out_idx`=idx.
  - `out_last`=(idx==len-1).
- Transfer occurs on a cycle with `out_valid`&&`out_ready`:
  - acc[c] += out_data[c], zero-extended to WIDTH+AW. Overflow is impossible by width.
  - idx increments.
- Transfer with `out_last`=1:
  - `sum`←final acc values, and `sum_valid` pulses.
  - Non-repeat: go to DONE.
  - Repeat: idx←0, accumulators cleared, stay in STREAM.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while in STREAM is ignored.
- `abort` in STREAM: go to IDLE next cycle. No `sum_valid`, no `done`; `sum` keeps its prior value. `abort` has priority over a simultaneous transfer, and that transfer is not counted.
- `out_data`/`out_idx` are don't-care while `out_valid`=0.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_idx`=0, `sum`=0, `sum_valid`=0, `done`=0, `busy`=0, `err`=0, state IDLE.
- `rst` mid-stream returns to IDLE on the next edge. Memory is kept.
- `start` sampled at edge t: `out_valid`=1 with idx 0 from cycle t+1.
- Latency: zero bubbles. Each ready cycle moves one sample, so throughput is 1 sample/cycle.
- `out_valid`/`out_data` are stable while `out_ready`=0.
- Last transfer at edge L:
  - `sum_valid`=1 during cycle L+1.
  - Non-repeat: `done`=1 and `out_valid`=0 during L+1; IDLE at L+2, when a new `start` is accepted.
  - Repeat: idx 0 is presented in cycle L+1 with no gap.
- A write in the same cycle as an accepted `start` is performed before streaming begins.

## Test plan
- Write ch0[0..3]=1.0,2.0,3.0,0.5 (20'h00400, 20'h00800, 20'h00C00, 20'h00200) and ch1=4×1.0; `start`, `len`=4, `out_ready`=1 -> 4 consecutive beats idx 0..3; `out_last` on beat 3; ch0 sum=6.5 (28'h0001A00); ch1 sum=4.0 (28'h0001000); `done` and `sum_valid` pulse together one cycle after the last beat.
- Same data, `out_ready` toggling 1,0,0,1,... -> data held across stalls; identical sums; beat count 4.
- `repeat_mode`=1, `len`=2 -> idx sequence 0,1,0,1,...; `sum_valid` every 2 accepted beats with identical totals; `done` never asserts; `abort` -> `out_valid`=0 next cycle and `busy`=0.
- `start` with `len`=0 and `len`=151 -> stays in IDLE and `err`=1; a write during STREAM -> ignored and `err`=1; a valid `start` clears `err`.
- `rst` asserted mid-stream at idx 2 -> all outputs at reset values next cycle; a restart streams the previously written memory unchanged.
- Full depth: DEPTH=150, all entries 20'hFFFFF -> sum=150×1048575=157286250 with no overflow in 28 bits.
